sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-in/parallel-out deserializer: the receiving end of the team's shift-register serial link. It samples `serialin_i` on every clock where `move_i` is high, assembles `WIDTH` bits into a word, then transfers the word to a holding register presented with a valid/ready handshake. It sits between the serial link and any parallel consumer, such as a register file or display logic. It also reports the partial bit count and a sticky overrun flag.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in bit `WIDTH-1`; 0 means it lands in bit 0.
- `clk_i`  in  1  single clock; all logic updates on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-low (0 = reset, sampled on the `clk_i` rising edge).
- `serialin_i`  in  1  serial data bit.
- `move_i`  in  1  bit strobe; when 1, `serialin_i` is shifted in this cycle.
- `clear_i`  in  1  synchronous flush of the partial word and of `overrun_o`.
- `ready_i`  in  1  consumer accepts the word on `parallelout_o`.
- `parallelout_o`  out  WIDTH  holding-register word.
- `valid_o`  out  1  holding register contains an unconsumed word.
- `count_o`  out  clog2(WIDTH+1)  bits received in the current partial word.
- `overrun_o`  out  1  sticky flag: a completed word was dropped.

## Operation
- Internal state:
  - shift register `sh` (WIDTH bits)
  - bit counter `cnt` (0..WIDTH-1)
  - holding register `hold`, driven onto `parallelout_o`
  - holding flag `valid_o`
  - `overrun_o`
- Holding-side FSM states:
  - EMPTY (`valid_o`=0)
  - FULL (`valid_o`=1)
- Shift side:
  - `move_i`=1 with `cnt` < WIDTH-1: shift the bit in and increment `cnt`.
  - For `MSB_FIRST`=1: `sh <= {sh[WIDTH-2:0], serialin_i}`.
  - For `MSB_FIRST`=0: `sh <= {serialin_i, sh[WIDTH-1:1]}`.
- Word completion is a `move_i`=1 cycle with `cnt`=WIDTH-1.
  - The completed word is the shifted value including the current bit.
  - `cnt` wraps to 0.
- On completion in EMPTY: `hold` takes the completed word, and the FSM goes to FULL.
- On completion in FULL with `ready_i`=1 (simultaneous consume and complete):
  - `hold` takes the new word.
  - The FSM stays FULL.
  - No overrun.
- On completion in FULL with `ready_i`=0:
  - The new word is dropped; `hold` is unchanged.
  - `overrun_o` is set to 1.
  - `cnt` still wraps to 0.
- FULL with `ready_i`=1 and no completion: go to EMPTY. `hold` keeps its stale value; consumers ignore it.
- `ready_i` is ignored in EMPTY.
- `clear_i`=1, with priority over `move_i`:
  - Sets `cnt` to 0 and `sh` to 0.
  - Sets `overrun_o` to 0.
  - The current `serialin_i` is not sampled.
  - The holding side is not affected; a handshake on `ready_i` still completes in the same cycle.
- Reset (`rst_i`=0), at any time including mid-word, applies at the next rising edge:
  - `sh`=0, `cnt`=0, `hold`=0
  - `valid_o`=0, `overrun_o`=0
  - FSM = EMPTY
  - Reset overrides `clear_i`, `move_i` and `ready_i`.
- `count_o` = `cnt`.
- `move_i`=0: `sh` and `cnt` hold their values; no timeout.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: the last bit is sampled at edge N; `valid_o` and `parallelout_o` show the word right after edge N, i.e. a 1-cycle latency.
- Handshake: a transfer occurs at a rising edge where `valid_o`=1 and `ready_i`=1. `valid_o` never deasserts without a transfer, except on reset.
- Back-to-back: with `move_i` held high and `ready_i` held high, one word is delivered every WIDTH cycles with no gaps and no overrun.
- Out-of-range value: with WIDTH=8, `cnt` never exceeds 7.
- Out-of-range value: `count_o` never reads 8.
- `overrun_o` is visible the cycle after the dropped completion and stays high until `clear_i` or reset.

## Test plan
- Reset, then single word, WIDTH=8, `MSB_FIRST`=1:
  - Stimulus: reset low for 2 cycles; shift 1,0,1,0,0,1,0,1 with `move_i`=1 and `ready_i`=0.
  - Required: `valid_o`=1 and `parallelout_o`=0xA5 right after the 8th edge; `count_o` steps 1..7, then 0.
- Bit order:
  - Stimulus: same bit stream with `MSB_FIRST`=0.
  - Required: `parallelout_o`=0xA5 (the 0xA5 stream is a bit-palindrome); repeat with stream 1,1,0,0,0,0,0,0.
  - Required for the second stream: 0x03 (LSB-first) versus 0xC0 (MSB-first).
- Gapped strobe:
  - Stimulus: insert `move_i`=0 gaps of 3 cycles between bits.
  - Required: same word; `count_o` holds during gaps; the `serialin_i` value during gaps is ignored.
- Simultaneous consume and complete:
  - Stimulus: word 0x11 held with `valid_o`=1; `ready_i`=1 exactly on the completion edge of 0x22.
  - Required: `valid_o` stays 1, `parallelout_o`=0x22, `overrun_o`=0.
- Overrun and clear:
  - Stimulus: hold `ready_i`=0 across two completions (0x11, then 0x33).
  - Required: `parallelout_o`=0x11, `overrun_o`=1.
  - Stimulus: `clear_i`=1 for one cycle.
  - Required: `overrun_o`=0, `count_o`=0, `valid_o` still 1.
- Mid-word reset and clear:
  - Stimulus: after 5 bits, `rst_i`=0 for 1 cycle.
  - Required: all outputs 0; the next 8 bits form a fresh word.
  - Stimulus: `clear_i`=1 together with `move_i`=1 after 3 bits.
  - Required: `count_o`=0; that bit is not counted.

Source files
------------

// File: rtl/sipo_deser_if.sv
// Serial-link receive bundle: serial bit, strobe, flush, and the parallel word handshake.
// Latency: none; wires only.
// Backpressure: the consumer drives ready_i against valid_o; the serial side has no backpressure.
// Ports:
//   master: serial source plus consumer (drives serialin_i/move_i/clear_i/ready_i).
//   slave : deserializer (drives parallelout_o/valid_o/count_o/overrun_o).
interface sipo_deser_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             serialin_i;
    logic             move_i;
    logic             clear_i;
    logic             ready_i;
    logic [WIDTH-1:0] parallelout_o;
    logic             valid_o;
    logic [CW-1:0]    count_o;
    logic             overrun_o;

    modport master (
        output serialin_i, move_i, clear_i, ready_i,
        input  parallelout_o, valid_o, count_o, overrun_o
    );

    modport slave (
        input  serialin_i, move_i, clear_i, ready_i,
        output parallelout_o, valid_o, count_o, overrun_o
    );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a one-word holding register and sticky overrun flag.
// Latency: 1 cycle from the edge sampling the last bit to valid_o/parallelout_o.
// Backpressure: none toward the link; a word completing while the holder is full and not consumed is dropped.
// Ports:
//   clk_i  : clock, rising edge.
//   rst_i  : synchronous active-low reset.
//   bus    : sipo_deser_if.slave (serial in, strobe, clear, ready / word, valid, count, overrun).
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    sipo_deser_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             ovr, ovr_n;

    logic [WIDTH-1:0] shifted;
    logic             complete;

    // Bit order only changes which end the new bit enters from.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sh[WIDTH-2:0], bus.serialin_i};
        end else begin : g_lsb
            assign shifted = {bus.serialin_i, sh[WIDTH-1:1]};
        end
    endgenerate

    // clear_i blocks sampling, so a cleared cycle can never complete a word.
    assign complete = bus.move_i && !bus.clear_i && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= EMPTY;
            sh    <= '0;
            cnt   <= '0;
            hold  <= '0;
            ovr   <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
            hold  <= hold_n;
            ovr   <= ovr_n;
        end
    end

    // Shift side.
    always_comb begin
        sh_n  = sh;
        cnt_n = cnt;
        if (bus.clear_i) begin
            sh_n  = '0;
            cnt_n = '0;
        end else if (bus.move_i) begin
            sh_n  = shifted;
            cnt_n = complete ? '0 : cnt + CW'(1);
        end
    end

    // Holding side. hold is left stale after a consume; valid_o alone qualifies it.
    always_comb begin
        state_n = state;
        hold_n  = hold;
        ovr_n   = ovr;
        unique case (state)
            EMPTY: begin
                if (complete) begin
                    hold_n  = shifted;
                    state_n = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    if (bus.ready_i) begin
                        hold_n = shifted;
                    end else begin
                        ovr_n = 1'b1;
                    end
                end else if (bus.ready_i) begin
                    state_n = EMPTY;
                end
            end
            default: state_n = EMPTY;
        endcase
        // Flush wins over a same-cycle overrun; the two cannot coincide anyway.
        if (bus.clear_i) begin
            ovr_n = 1'b0;
        end
    end

    assign bus.parallelout_o = hold;
    assign bus.valid_o       = (state == FULL);
    assign bus.count_o       = cnt;
    assign bus.overrun_o     = ovr;
endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic serialin, move, clear, ready;

    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(W)) if_m ();
    sipo_deser_if #(.WIDTH(W)) if_l ();

    assign if_m.serialin_i = serialin;
    assign if_m.move_i     = move;
    assign if_m.clear_i    = clear;
    assign if_m.ready_i    = ready;
    assign if_l.serialin_i = serialin;
    assign if_l.move_i     = move;
    assign if_l.clear_i    = clear;
    assign if_l.ready_i    = ready;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk_i(clk), .rst_i(rst_n), .bus(if_m));
    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk_i(clk), .rst_i(rst_n), .bus(if_l));

    int tests = 0;
    int fails = 0;

    // Reference model: bits kept in arrival order, word built by weighting.
    int          bits_q[$];
    logic        m_valid;
    logic [W-1:0] m_hold_m, m_hold_l;
    logic        m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic         done;
        logic [W-1:0] wm, wl;
        done = 1'b0;
        wm = '0;
        wl = '0;
        if (!rst_n) begin
            bits_q.delete();
            m_valid  = 1'b0;
            m_hold_m = '0;
            m_hold_l = '0;
            m_ovr    = 1'b0;
        end else begin
            if (clear) begin
                bits_q.delete();
                m_ovr = 1'b0;
            end else if (move) begin
                bits_q.push_back(int'(serialin));
                if (bits_q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm = wm | (W'(bits_q[i]) << (W - 1 - i));
                        wl = wl | (W'(bits_q[i]) << i);
                    end
                    bits_q.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || ready) begin
                    m_hold_m = wm;
                    m_hold_l = wl;
                    m_valid  = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("valid_msb", 32'(if_m.valid_o), 32'(m_valid));
        check("valid_lsb", 32'(if_l.valid_o), 32'(m_valid));
        check("data_msb", 32'(if_m.parallelout_o), 32'(m_hold_m));
        check("data_lsb", 32'(if_l.parallelout_o), 32'(m_hold_l));
        check("count_msb", 32'(if_m.count_o), 32'(bits_q.size()));
        check("count_lsb", 32'(if_l.count_o), 32'(bits_q.size()));
        check("ovr_msb", 32'(if_m.overrun_o), 32'(m_ovr));
        check("ovr_lsb", 32'(if_l.overrun_o), 32'(m_ovr));
    endtask

    // One clock: inputs are stable across the edge, model advances, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        move     = 1'b0;
        clear    = 1'b0;
        ready    = 1'b0;
        serialin = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
    endtask

    task automatic shift_bit(input logic v, input int gap);
        serialin = v;
        move     = 1'b1;
        tick();
        move = 1'b0;
        for (int g = 0; g < gap; g++) begin
            serialin = 1'($urandom);
            tick();
        end
    endtask

    // Sends b[7] first.
    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) shift_bit(b[i], 0);
        move = 1'b0;
    endtask

    typedef struct {
        logic [7:0] stream;   // stream[7] is the first bit on the wire
        int         gap;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t vecs[3];

    initial begin
        vecs[0] = '{stream: 8'hA5, gap: 0, exp_msb: 8'hA5, exp_lsb: 8'hA5};
        vecs[1] = '{stream: 8'hC0, gap: 0, exp_msb: 8'hC0, exp_lsb: 8'h03};
        vecs[2] = '{stream: 8'hA5, gap: 3, exp_msb: 8'hA5, exp_lsb: 8'hA5};

        idle_inputs();
        rst_n = 1'b0;

        // Reset state.
        do_reset(2);
        check("rst_valid", 32'(if_m.valid_o), 32'd0);
        check("rst_data", 32'(if_m.parallelout_o), 32'd0);
        check("rst_count", 32'(if_m.count_o), 32'd0);
        check("rst_ovr", 32'(if_m.overrun_o), 32'd0);

        // Table-driven single words with ready held low.
        foreach (vecs[v]) begin
            idle_inputs();
            do_reset(1);
            for (int k = 0; k < 8; k++) begin
                check("pre_valid", 32'(if_m.valid_o), 32'd0);
                shift_bit(vecs[v].stream[7 - k], 0);
                check("count_step", 32'(if_m.count_o), 32'((k + 1) % 8));
                if (vecs[v].gap > 0) begin
                    move = 1'b0;
                    for (int g = 0; g < vecs[v].gap; g++) begin
                        serialin = 1'($urandom);
                        tick();
                        check("count_hold", 32'(if_m.count_o), 32'((k + 1) % 8));
                    end
                end
            end
            move = 1'b0;
            check("vec_valid", 32'(if_m.valid_o), 32'd1);
            check("vec_msb", 32'(if_m.parallelout_o), 32'(vecs[v].exp_msb));
            check("vec_lsb", 32'(if_l.parallelout_o), 32'(vecs[v].exp_lsb));
        end

        // Simultaneous consume and complete.
        idle_inputs();
        do_reset(1);
        send_byte(8'h11);
        for (int i = 7; i >= 1; i--) shift_bit(1'((8'h22 >> i) & 8'h1), 0);
        ready = 1'b1;
        shift_bit(1'b0, 0);
        move  = 1'b0;
        ready = 1'b0;
        check("cc_valid", 32'(if_m.valid_o), 32'd1);
        check("cc_data", 32'(if_m.parallelout_o), 32'h22);
        check("cc_ovr", 32'(if_m.overrun_o), 32'd0);

        // Overrun, then clear.
        idle_inputs();
        do_reset(1);
        send_byte(8'h11);
        send_byte(8'h33);
        check("ovr_data", 32'(if_m.parallelout_o), 32'h11);
        check("ovr_flag", 32'(if_m.overrun_o), 32'd1);
        tick();
        check("ovr_sticky", 32'(if_m.overrun_o), 32'd1);
        shift_bit(1'b1, 0);
        shift_bit(1'b0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_ovr", 32'(if_m.overrun_o), 32'd0);
        check("clr_count", 32'(if_m.count_o), 32'd0);
        check("clr_valid", 32'(if_m.valid_o), 32'd1);

        // Clear with a handshake in the same cycle: consume still completes.
        clear = 1'b1;
        ready = 1'b1;
        tick();
        clear = 1'b0;
        ready = 1'b0;
        check("clr_rdy_valid", 32'(if_m.valid_o), 32'd0);

        // Mid-word reset.
        idle_inputs();
        send_byte(8'h5A);
        for (int i = 0; i < 5; i++) shift_bit(1'b1, 0);
        move = 1'b0;
        do_reset(1);
        check("mrst_valid", 32'(if_m.valid_o), 32'd0);
        check("mrst_data", 32'(if_m.parallelout_o), 32'd0);
        check("mrst_count", 32'(if_m.count_o), 32'd0);
        check("mrst_ovr", 32'(if_m.overrun_o), 32'd0);
        send_byte(8'h3C);
        check("mrst_word", 32'(if_m.parallelout_o), 32'h3C);

        // Clear together with move after 3 bits: that bit is dropped.
        idle_inputs();
        do_reset(1);
        for (int i = 0; i < 3; i++) shift_bit(1'b1, 0);
        serialin = 1'b1;
        move     = 1'b1;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        move  = 1'b0;
        check("cm_count", 32'(if_m.count_o), 32'd0);
        send_byte(8'h81);
        check("cm_word", 32'(if_m.parallelout_o), 32'h81);
        check("cm_valid", 32'(if_m.valid_o), 32'd1);

        // Back-to-back streaming: no gaps, no overrun.
        idle_inputs();
        do_reset(1);
        move  = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 5 * W; i++) begin
            serialin = 1'($urandom);
            tick();
        end
        check("b2b_valid", 32'(if_m.valid_o), 32'd1);
        check("b2b_ovr", 32'(if_m.overrun_o), 32'd0);

        // Randomized traffic against the model.
        idle_inputs();
        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            serialin = 1'($urandom);
            move     = ($urandom_range(0, 9) < 7);
            ready    = ($urandom_range(0, 9) < 2);
            clear    = ($urandom_range(0, 39) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
